// File: rtl/mem_arbiter_pkg.sv
// Shared types and FSM encodings for the heap memory arbiter.
package mem_arbiter_pkg;

   // Heap word is word_size + 1 bits wide (tag plus payload).
   localparam int unsigned WordSize = 15;
   typedef logic [WordSize:0] word_t;

   // Arbiter FSM encoding, kept as plain constants for legacy tools.
   typedef logic [1:0] arb_state_t;
   localparam arb_state_t ARB_IDLE    = 2'd0;
   localparam arb_state_t ARB_ACCESS  = 2'd1;
   localparam arb_state_t ARB_WAIT    = 2'd2;
   localparam arb_state_t ARB_RESPOND = 2'd3;

endpackage

// File: rtl/mem_arbiter_if.sv
// Client-side request/response bundle of the heap memory arbiter.
interface mem_arbiter_if #(
   parameter int unsigned NumRequesters = 2,
   parameter int unsigned AddrWidth     = 16,
   parameter int unsigned DataWidth     = 16
);

   logic [NumRequesters-1:0] req_valid;
   logic [NumRequesters-1:0] req_ready;
   logic [AddrWidth-1:0]     req_addr  [NumRequesters];
   logic [NumRequesters-1:0] req_we;
   logic [DataWidth-1:0]     req_wdata [NumRequesters];
   logic [NumRequesters-1:0] rsp_valid;
   logic [DataWidth-1:0]     rsp_data;

   // Clients drive requests and observe grants/responses.
   modport master (
      output req_valid, req_addr, req_we, req_wdata,
      input  req_ready, rsp_valid, rsp_data
   );

   // The arbiter consumes requests and produces grants/responses.
   modport slave (
      input  req_valid, req_addr, req_we, req_wdata,
      output req_ready, rsp_valid, rsp_data
   );

endinterface

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin picker: first valid client at or after rr_ptr.
module mem_arbiter_rr_picker
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned NumRequesters = 2,
   localparam int unsigned PtrWidth     = $clog2(NumRequesters)
) (
   input  logic [NumRequesters-1:0] i_valid,
   input  logic [PtrWidth-1:0]      i_rr_ptr,
   output logic [PtrWidth-1:0]      o_grant,
   output logic                     o_any_valid
);

   localparam logic [PtrWidth-1:0] LastIdx = PtrWidth'(NumRequesters - 1);

   logic [PtrWidth-1:0] w_idx;

   // Walk the ring from rr_ptr with explicit wrap so non-power-of-two counts work.
   always_comb begin
      o_grant     = '0;
      o_any_valid = 1'b0;
      w_idx       = i_rr_ptr;
      for (int k = 0; k < NumRequesters; k++) begin
         if (!o_any_valid && i_valid[w_idx]) begin
            o_grant     = w_idx;
            o_any_valid = 1'b1;
         end
         w_idx = (w_idx == LastIdx) ? '0 : w_idx + PtrWidth'(1);
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port heap memory among several clients.
// One transaction in flight; read data is collected after a fixed memory latency.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned NumRequesters = 2,
   parameter int unsigned AddrWidth     = 16,
   parameter int unsigned DataWidth     = 16,
   parameter int unsigned ReadLatency   = 2
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   mem_arbiter_if.slave         io_bus,
   output logic [AddrWidth-1:0] o_mem_addr,
   output logic                 o_mem_we,
   output logic [DataWidth-1:0] o_mem_wdata,
   input  logic [DataWidth-1:0] i_mem_rdata
);

   localparam int unsigned PtrWidth = $clog2(NumRequesters);
   localparam int unsigned CntWidth = $clog2(ReadLatency + 1);
   localparam logic [PtrWidth-1:0] LastIdx = PtrWidth'(NumRequesters - 1);
   localparam logic [CntWidth-1:0] CntLast = CntWidth'(ReadLatency - 1);

   if (NumRequesters < 2) begin : g_bad_num_requesters
      $fatal(1, "mem_arbiter: NumRequesters must be >= 2");
   end
   if (ReadLatency < 1) begin : g_bad_read_latency
      $fatal(1, "mem_arbiter: ReadLatency must be >= 1");
   end

   arb_state_t              r_state;
   logic [PtrWidth-1:0]     r_rr_ptr;
   logic [PtrWidth-1:0]     r_grant;
   logic                    r_we;
   logic [CntWidth-1:0]     r_wait_cnt;
   logic [DataWidth-1:0]    r_rsp_data;
   logic [AddrWidth-1:0]    r_mem_addr;
   logic                    r_mem_we;
   logic [DataWidth-1:0]    r_mem_wdata;

   logic [PtrWidth-1:0]      w_grant;
   logic                     w_any_valid;
   logic                     w_hs;
   logic [NumRequesters-1:0] w_req_ready;
   logic [NumRequesters-1:0] w_rsp_valid;

   mem_arbiter_rr_picker #(
      .NumRequesters (NumRequesters)
   ) u_rr_picker (
      .i_valid     (io_bus.req_valid),
      .i_rr_ptr    (r_rr_ptr),
      .o_grant     (w_grant),
      .o_any_valid (w_any_valid)
   );

   // A handshake can only happen while idle.
   assign w_hs = (r_state == ARB_IDLE) && w_any_valid;

   // One-hot accept toward the picked client, combinational in IDLE.
   always_comb begin
      w_req_ready = '0;
      if (w_hs) begin
         w_req_ready[w_grant] = 1'b1;
      end
   end

   // One-cycle completion strobe toward the client being served.
   always_comb begin
      w_rsp_valid = '0;
      if (r_state == ARB_RESPOND) begin
         w_rsp_valid[r_grant] = 1'b1;
      end
   end

   // Transaction sequencer: grant, drive memory, wait out latency, respond.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= ARB_IDLE;
         r_rr_ptr    <= '0;
         r_grant     <= '0;
         r_we        <= 1'b0;
         r_wait_cnt  <= '0;
         r_rsp_data  <= '0;
         r_mem_addr  <= '0;
         r_mem_we    <= 1'b0;
         r_mem_wdata <= '0;
      end else begin
         case (r_state)
            ARB_IDLE: begin
               if (w_hs) begin
                  r_grant     <= w_grant;
                  r_mem_addr  <= io_bus.req_addr[w_grant];
                  r_mem_wdata <= io_bus.req_wdata[w_grant];
                  r_we        <= io_bus.req_we[w_grant];
                  // Write strobe is visible only during the ACCESS cycle.
                  r_mem_we    <= io_bus.req_we[w_grant];
                  r_state     <= ARB_ACCESS;
               end
            end
            ARB_ACCESS: begin
               r_mem_we   <= 1'b0;
               r_wait_cnt <= '0;
               r_state    <= ARB_WAIT;
            end
            ARB_WAIT: begin
               if (r_wait_cnt == CntLast) begin
                  r_rsp_data <= r_we ? r_mem_wdata : i_mem_rdata;
                  r_wait_cnt <= '0;
                  r_state    <= ARB_RESPOND;
               end else begin
                  r_wait_cnt <= r_wait_cnt + CntWidth'(1);
               end
            end
            ARB_RESPOND: begin
               r_rr_ptr <= (r_grant == LastIdx) ? '0 : r_grant + PtrWidth'(1);
               r_state  <= ARB_IDLE;
            end
            default: begin
               r_state <= ARB_IDLE;
            end
         endcase
      end
   end

   assign io_bus.req_ready = w_req_ready;
   assign io_bus.rsp_valid = w_rsp_valid;
   assign io_bus.rsp_data  = r_rsp_data;
   assign o_mem_addr       = r_mem_addr;
   assign o_mem_we         = r_mem_we;
   assign o_mem_wdata      = r_mem_wdata;

endmodule
